// File: rtl/led_row_scan_ctrl.sv
// LED matrix row scan sequencer.
// For each row, the block runs these steps in order:
//   1. Request the pixel row from the frame source over a req/valid handshake.
//   2. Shift the red/green/blue bit-planes out serially, pixel 0 first.
//   3. Blank the panel and update the row address.
//   4. Latch the shifted data.
//   5. Display the row for a fixed time, then advance to the next row.
// All outputs are registered.
//
// Ports:
//   sys_clk, sys_rst_n  clock; asynchronous active-low reset (assert async, release sync)
//   enable              run the scan; only looked at when a row is finished or in idle
//   row_req             row data request; row_req_addr holds the row number while it is high
//   row_valid/row_data  row data {red, green, blue}, each NUM_COL_PIXELS bits wide;
//                       taken only while row_req is high
//   led_r/g/b, led_clk  serial pixel data and shift clock; the panel samples on the led_clk rise
//   led_lat, led_oe_n   one-cycle latch strobe; output enable (active low)
//   led_addr            row select for the panel
//   frame_start         one-cycle pulse with the first request for row 0
module led_row_scan_ctrl #(
   parameter int unsigned NUM_COL_PIXELS = 64,
   parameter int unsigned NUM_ROWS       = 16,
   parameter int unsigned ROW_ADDR_W     = 4,
   parameter int unsigned CLK_DIV        = 2,
   parameter int unsigned BLANK_CYCLES   = 4,
   parameter int unsigned DISPLAY_CYCLES = 256
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic                          enable,
   output logic                          row_req,
   output logic [ROW_ADDR_W-1:0]         row_req_addr,
   input  logic                          row_valid,
   input  logic [3*NUM_COL_PIXELS-1:0]   row_data,
   output logic                          led_r,
   output logic                          led_g,
   output logic                          led_b,
   output logic                          led_clk,
   output logic                          led_lat,
   output logic                          led_oe_n,
   output logic [ROW_ADDR_W-1:0]         led_addr,
   output logic                          frame_start
);

   localparam int unsigned N       = NUM_COL_PIXELS;
   localparam int unsigned MAX_AB  = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_AB > DISPLAY_CYCLES) ? MAX_AB : DISPLAY_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned PIX_W   = $clog2(N + 1);

   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]      BLNK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]      DISP_LAST = CNT_W'(DISPLAY_CYCLES - 1);
   localparam logic [PIX_W-1:0]      PIX_ONE   = PIX_W'(1);
   localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(N - 1);
   localparam logic [ROW_ADDR_W-1:0] ROW_ONE   = ROW_ADDR_W'(1);
   localparam logic [ROW_ADDR_W-1:0] ROW_LAST  = ROW_ADDR_W'(NUM_ROWS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StShift,
      StBlank,
      StLatch,
      StDisplay
   } state_e;

   // Reset release is synchronised locally; assertion still clears every flop at once.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   state_e                state_q;
   logic [ROW_ADDR_W-1:0] row_idx_q;
   logic [ROW_ADDR_W-1:0] row_next;
   logic [CNT_W-1:0]      cnt_q;
   logic [PIX_W-1:0]      pix_q;
   logic [N-1:0]          sr_r_q;
   logic [N-1:0]          sr_g_q;
   logic [N-1:0]          sr_b_q;

   assign row_next = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ROW_ONE;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         row_idx_q    <= '0;
         cnt_q        <= '0;
         pix_q        <= '0;
         sr_r_q       <= '0;
         sr_g_q       <= '0;
         sr_b_q       <= '0;
         row_req      <= 1'b0;
         row_req_addr <= '0;
         led_r        <= 1'b0;
         led_g        <= 1'b0;
         led_b        <= 1'b0;
         led_clk      <= 1'b0;
         led_lat      <= 1'b0;
         led_oe_n     <= 1'b1;
         led_addr     <= '0;
         frame_start  <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         led_lat     <= 1'b0;
         case (state_q)
            StIdle: begin
               if (enable) begin
                  state_q      <= StReq;
                  row_req      <= 1'b1;
                  row_req_addr <= row_idx_q;
                  frame_start  <= (row_idx_q == '0);
               end
            end
            StReq: begin
               if (row_valid) begin
                  state_q <= StShift;
                  row_req <= 1'b0;
                  sr_r_q  <= row_data[3*N-1:2*N];
                  sr_g_q  <= row_data[2*N-1:N];
                  sr_b_q  <= row_data[N-1:0];
                  // Pixel 0 goes out right away so it is held for its whole period.
                  led_r   <= row_data[2*N];
                  led_g   <= row_data[N];
                  led_b   <= row_data[0];
                  led_clk <= 1'b0;
                  cnt_q   <= '0;
                  pix_q   <= '0;
               end
            end
            StShift: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (!led_clk) begin
                     led_clk <= 1'b1;
                  end else begin
                     led_clk <= 1'b0;
                     if (pix_q == PIX_LAST) begin
                        state_q  <= StBlank;
                        led_r    <= 1'b0;
                        led_g    <= 1'b0;
                        led_b    <= 1'b0;
                        led_addr <= row_idx_q;
                     end else begin
                        // sr[0] holds the pixel on the pins; sr[1] is the next one.
                        pix_q  <= pix_q + PIX_ONE;
                        led_r  <= sr_r_q[1];
                        led_g  <= sr_g_q[1];
                        led_b  <= sr_b_q[1];
                        sr_r_q <= sr_r_q >> 1;
                        sr_g_q <= sr_g_q >> 1;
                        sr_b_q <= sr_b_q >> 1;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            StBlank: begin
               if (cnt_q == BLNK_LAST) begin
                  state_q <= StLatch;
                  led_lat <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            StLatch: begin
               state_q  <= StDisplay;
               led_oe_n <= 1'b0;
               cnt_q    <= '0;
            end
            StDisplay: begin
               if (cnt_q == DISP_LAST) begin
                  cnt_q     <= '0;
                  led_oe_n  <= 1'b1;
                  row_idx_q <= row_next;
                  if (enable) begin
                     state_q      <= StReq;
                     row_req      <= 1'b1;
                     row_req_addr <= row_next;
                     frame_start  <= (row_next == '0);
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_row_scan_ctrl.sv
// Bench for led_row_scan_ctrl.
// A table of per-row records drives the scan. Each record holds the row data, the handshake
// delay and whether to drop enable, plus the expected request address and frame_start. The bench
// also checks reset behaviour, the idle stop and a reset asserted mid-shift.
module tb_led_row_scan_ctrl;

   localparam int N     = 64;
   localparam int AW    = 4;
   localparam int CDIV  = 2;
   localparam int BLANK = 4;
   localparam int DISP  = 256;
   localparam int NVEC  = 17;

   logic          sys_clk   = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          enable    = 1'b0;
   logic          row_valid = 1'b0;
   logic [3*N-1:0] row_data = '0;
   logic          row_req;
   logic [AW-1:0] row_req_addr;
   logic          led_r;
   logic          led_g;
   logic          led_b;
   logic          led_clk;
   logic          led_lat;
   logic          led_oe_n;
   logic [AW-1:0] led_addr;
   logic          frame_start;

   led_row_scan_ctrl #(
      .NUM_COL_PIXELS (N),
      .NUM_ROWS       (16),
      .ROW_ADDR_W     (AW),
      .CLK_DIV        (CDIV),
      .BLANK_CYCLES   (BLANK),
      .DISPLAY_CYCLES (DISP)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .enable       (enable),
      .row_req      (row_req),
      .row_req_addr (row_req_addr),
      .row_valid    (row_valid),
      .row_data     (row_data),
      .led_r        (led_r),
      .led_g        (led_g),
      .led_b        (led_b),
      .led_clk      (led_clk),
      .led_lat      (led_lat),
      .led_oe_n     (led_oe_n),
      .led_addr     (led_addr),
      .frame_start  (frame_start)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int unsigned   delay;     // cycles row_valid is held off after row_req is seen
      bit            drop_en;   // drop enable right after the handshake
      logic [N-1:0]  red;
      logic [N-1:0]  green;
      logic [N-1:0]  blue;
      logic [AW-1:0] exp_addr;
      bit            exp_fs;
   } row_vec_t;

   row_vec_t vec [NVEC];

   int checks   = 0;
   int failures = 0;

   // Monitor state, updated once per cycle by tick().
   int           cyc = 0;
   bit           prev_clk = 1'b0;
   int           rise_cnt = 0;
   logic [N-1:0] cap_r = '0;
   logic [N-1:0] cap_g = '0;
   logic [N-1:0] cap_b = '0;
   int           first_rise_cyc = 0;
   int           last_high_cyc = 0;
   int           lat_cnt = 0;
   int           lat_cyc = 0;
   int           fs_cnt = 0;
   int           oe_low_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge sys_clk);
      cyc++;
      if (led_clk && !prev_clk) begin
         if (rise_cnt == 0) first_rise_cyc = cyc;
         if (rise_cnt < N) begin
            cap_r[rise_cnt] = led_r;
            cap_g[rise_cnt] = led_g;
            cap_b[rise_cnt] = led_b;
         end
         rise_cnt++;
      end
      if (led_clk) last_high_cyc = cyc;
      prev_clk = led_clk;
      if (led_lat) begin
         lat_cnt++;
         lat_cyc = cyc;
      end
      if (frame_start) fs_cnt++;
      if (!led_oe_n) oe_low_cnt++;
   endtask

   task automatic run_row(input row_vec_t v);
      int            n;
      int            stall_bad;
      int            lat0;
      logic [AW-1:0] a0;
      n = 0;
      while (!row_req && n < 3000) begin
         tick();
         n++;
      end
      check("req_seen", 64'(row_req), 64'd1);
      check("req_addr", 64'(row_req_addr), 64'(v.exp_addr));
      check("frame_start", 64'(frame_start), 64'(v.exp_fs));
      check("req_oe_n", 64'(led_oe_n), 64'd1);
      a0 = row_req_addr;
      stall_bad = 0;
      for (int i = 0; i < int'(v.delay); i++) begin
         tick();
         if (!row_req || row_req_addr !== a0 || !led_oe_n || frame_start) stall_bad++;
      end
      check("stall_stable", 64'(stall_bad), 64'd0);
      rise_cnt = 0;
      cap_r = '0;
      cap_g = '0;
      cap_b = '0;
      lat0 = lat_cnt;
      row_data  = {v.red, v.green, v.blue};
      row_valid = 1'b1;
      tick();
      row_valid = 1'b0;
      row_data  = ~row_data;
      check("req_drop", 64'(row_req), 64'd0);
      if (v.drop_en) enable = 1'b0;
      // A stray valid while row_req is low must not disturb the row being shifted.
      repeat (20) tick();
      row_valid = 1'b1;
      tick();
      row_valid = 1'b0;
      n = 0;
      while (lat_cnt == lat0 && n < 1000) begin
         tick();
         n++;
      end
      check("lat_seen", 64'(lat_cnt - lat0), 64'd1);
      check("rises", 64'(rise_cnt), 64'(N));
      check("data_r", cap_r, v.red);
      check("data_g", cap_g, v.green);
      check("data_b", cap_b, v.blue);
      check("shift_len", 64'(last_high_cyc - first_rise_cyc + CDIV + 1), 64'(2 * CDIV * N));
      check("lat_after_blank", 64'(lat_cyc - last_high_cyc), 64'(BLANK + 1));
      check("led_addr", 64'(led_addr), 64'(v.exp_addr));
      check("lat_idle_pins", 64'({led_oe_n, led_clk, led_r, led_g, led_b}), 64'h10);
      oe_low_cnt = 0;
      repeat (DISP) tick();
      check("display_len", 64'(oe_low_cnt), 64'(DISP));
      check("display_addr", 64'(led_addr), 64'(v.exp_addr));
      tick();
      check("display_end_oe", 64'(led_oe_n), 64'd1);
      check("single_lat", 64'(lat_cnt - lat0), 64'd1);
   endtask

   initial begin
      int         bad;
      int         n;
      int         lat0;
      logic [3:0] nib;

      vec[0] = '{1, 1'b0, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'd0, 1'b1};
      vec[1] = '{0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0};
      vec[2] = '{50, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'hF0F0_0F0F_F0F0_0F0F, 4'd2, 1'b0};
      vec[3] = '{2, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h8000_0000_CAFE_F00D,
                 64'h0000_FFFF_0000_FFFF, 4'd3, 1'b0};
      for (int i = 4; i < 16; i++) begin
         nib = 4'(i);
         vec[i].delay    = 32'(i % 3);
         vec[i].drop_en  = 1'b0;
         vec[i].red      = {16{nib}};
         vec[i].green    = ~{16{nib}};
         vec[i].blue     = {{16{nib}} >> 3};
         vec[i].exp_addr = nib;
         vec[i].exp_fs   = 1'b0;
      end
      vec[16] = '{1, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF,
                  64'h8000_0000_0000_0001, 4'd0, 1'b1};

      // Reset values while reset is held.
      repeat (3) tick();
      check("rst_oe_n", 64'(led_oe_n), 64'd1);
      check("rst_others", 64'({row_req, row_req_addr, led_r, led_g, led_b, led_clk, led_lat,
                               led_addr, frame_start}), 64'd0);

      // Released with enable low: stays idle.
      sys_rst_n = 1'b1;
      bad = 0;
      repeat (10) begin
         tick();
         if (row_req || !led_oe_n || led_lat || frame_start) bad++;
      end
      check("idle_no_req", 64'(bad), 64'd0);

      enable = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         run_row(vec[i]);
         if (vec[i].drop_en) begin
            // Row finished with enable low: block must sit idle, then resume at the next row.
            bad = 0;
            lat0 = lat_cnt;
            repeat (30) begin
               tick();
               if (row_req || !led_oe_n) bad++;
            end
            check("stopped_idle", 64'(bad), 64'd0);
            check("stopped_no_lat", 64'(lat_cnt - lat0), 64'd0);
            enable = 1'b1;
         end
      end
      check("frame_start_count", 64'(fs_cnt), 64'd2);

      // Reset in the middle of shifting row 1.
      check("pre_rst_req", 64'(row_req), 64'd1);
      check("pre_rst_addr", 64'(row_req_addr), 64'd1);
      row_data  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F};
      row_valid = 1'b1;
      tick();
      row_valid = 1'b0;
      repeat (100) tick();
      lat0 = lat_cnt;
      #2 sys_rst_n = 1'b0;
      #1;
      check("async_rst_oe_n", 64'(led_oe_n), 64'd1);
      check("async_rst_others", 64'({row_req, row_req_addr, led_r, led_g, led_b, led_clk,
                                     led_lat, led_addr, frame_start}), 64'd0);
      repeat (4) tick();
      sys_rst_n = 1'b1;
      n = 0;
      while (!row_req && n < 50) begin
         tick();
         n++;
      end
      check("post_rst_req", 64'(row_req), 64'd1);
      check("post_rst_addr", 64'(row_req_addr), 64'd0);
      check("post_rst_fs", 64'(frame_start), 64'd1);
      check("post_rst_no_lat", 64'(lat_cnt - lat0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
